bram_snap_ctrl: RTL and testbench

//  Triggered snapshot capture/readout controller. Sits directly upstream of bram_sync_sp and drives its wr/addr/data_in ports.
//  On arm+trigger it captures DEPTH=2**ADDR_WIDTH valid samples into the BRAM.
//  It then streams them back out in order over a valid/ready interface.

---
 rtl/bram_snap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_bram_snap_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_snap_ctrl.sv
// bram_snap_ctrl: triggered snapshot capture/readout controller for bram_sync_sp.
// Arm, then trigger on a valid sample. It captures 2**ADDR_WIDTH samples and
// streams them back over valid/ready. Optional macro BRAM_SNAP_ABORT_EN adds an
// abort input that returns the block to IDLE from any state.
module bram_snap_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
`ifdef BRAM_SNAP_ABORT_EN
  input  logic                  abort,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t state_q, state_d;

  logic                  abort_w;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;     // read-issue pointer, MSB set once all reads issued
  logic                  pend_q, pend_d;     // a read was issued last cycle; its data is on ram_dout
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  last_pop;
  logic                  issue;
  logic [1:0]            occ;

`ifdef BRAM_SNAP_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign pop      = (state_q == READOUT) && dout_vld_q && dout_rdy;
  // Last beat: everything issued and nothing left behind the output register.
  assign last_pop = pop && rptr_q[ADDR_WIDTH] && !skid_vld_q && !pend_q;
  assign occ      = 2'(dout_vld_q) + 2'(skid_vld_q) + 2'(pend_q);
  // Prefetch only when the returning word is guaranteed a slot (output or skid)
  // even if the consumer stalls next cycle.
  assign issue    = (state_q == READOUT) && !rptr_q[ADDR_WIDTH] && !abort_w &&
                    (occ <= (2'd1 + 2'(pop)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (trig && din_vld) state_d = CAPTURE;
      CAPTURE: if (din_vld && (count_q == LAST_CNT)) state_d = READOUT;
      READOUT: if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_w) state_d = IDLE;
  end

  // FSM outputs: BRAM write port and busy flag
  always_comb begin
    ram_wr   = !abort_w && (((state_q == ARMED) && trig && din_vld) ||
                            ((state_q == CAPTURE) && din_vld));
    ram_addr = '0;
    ram_din  = '0;
    if (ram_wr) begin
      ram_addr = count_q[ADDR_WIDTH-1:0];
      ram_din  = din;
    end else if (state_q == READOUT) begin
      ram_addr = rptr_q[ADDR_WIDTH-1:0];
    end
    busy = (state_q != IDLE);
  end

  // Datapath next-state: write count, read prefetch, output/skid registers
  always_comb begin
    count_d    = count_q;
    rptr_d     = rptr_q;
    pend_d     = issue;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    skid_d     = skid_q;
    skid_vld_d = 1'b0;
    done_d     = 1'b0;

    if (abort_w) begin
      count_d = '0;
    end else if ((state_q == IDLE) && arm) begin
      count_d = '0;
    end else if (ram_wr) begin
      count_d = count_q + CNT_ONE;
    end

    if (state_q != READOUT) begin
      rptr_d = '0;
    end else if (issue) begin
      rptr_d = rptr_q + CNT_ONE;
    end

    if ((state_q == READOUT) && !abort_w) begin
      dout_vld_d = dout_vld_q;
      skid_vld_d = skid_vld_q;
      if (!dout_vld_q || pop) begin
        // Output slot frees up: skid entry first, then the word returning now.
        if (skid_vld_q) begin
          dout_d     = skid_q;
          dout_vld_d = 1'b1;
          skid_d     = ram_dout;
          skid_vld_d = pend_q;
        end else if (pend_q) begin
          dout_d     = ram_dout;
          dout_vld_d = 1'b1;
        end else begin
          dout_vld_d = 1'b0;
        end
      end else if (pend_q) begin
        skid_d     = ram_dout;
        skid_vld_d = 1'b1;
      end
      done_d = last_pop;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rptr_q     <= '0;
      pend_q     <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      done_q     <= done_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_bram_snap_ctrl.sv
// Testbench for bram_snap_ctrl with a behavioural bram_sync_sp (registered read).
// Captured samples go into a scoreboard queue; accepted readout beats pop it.
module tb_bram_snap_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       trig = 1'b0;
  logic [7:0] din = '0;
  logic       din_vld = 1'b0;
  logic       dout_rdy = 1'b1;
  logic       abort_s = 1'b0;
  logic [7:0] dout;
  logic       dout_vld;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic       ram_wr;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int nbeats = 0;
  int first_beat = 0;
  int last_beat = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_dout = '0;
  logic [7:0] sb_q[$];
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  bram_snap_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .din(din), .din_vld(din_vld),
`ifdef BRAM_SNAP_ABORT_EN
    .abort(abort_s),
`endif
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .busy(busy), .done(done),
    .count(count), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // bram_sync_sp model
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Readout monitor: sampled mid-cycle, reflects what the next rising edge sees
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("hold_vld", 32'(dout_vld), 32'd1);
        chk("hold_val", 32'(dout), 32'(prev_dout));
      end
      if (dout_vld && dout_rdy) begin
        if (sb_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("beat", 32'(dout), 32'(e));
        end
        if (nbeats == 0) first_beat = cyc;
        last_beat = cyc;
        nbeats++;
      end
      prev_stall = dout_vld && !dout_rdy && !abort_s;
      prev_dout  = dout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_vld"}, 32'(dout_vld), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cnt"}, 32'(count), 32'd0);
    chk({tag, "_wr"}, 32'(ram_wr), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_din"}, 32'(ram_din), 32'd0);
  endtask

  task automatic do_arm;
    arm = 1'b1;
    #2;
    chk("arm_wr", 32'(ram_wr), 32'd0);
    tick();
    arm = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_cnt", 32'(count), 32'd0);
  endtask

  task automatic capture(input logic [7:0] base, input bit gaps, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      if (gaps && i > 0) begin
        din_vld = 1'b0; trig = 1'b0; din = 8'hEE;
        #2;
        chk("gap_wr", 32'(ram_wr), 32'd0);
        tick();
      end
      din = base + 8'(i); din_vld = 1'b1; trig = (i == 0);
      #2;
      chk("wr", 32'(ram_wr), 32'd1);
      chk("waddr", 32'(ram_addr), 32'(i));
      chk("wdata", 32'(ram_din), 32'(din));
      chk("wcnt", 32'(count), 32'(i));
      sb_q.push_back(din);
      tick();
    end
    din_vld = 1'b0; trig = 1'b0;
    if (nsamp == 16) begin
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_cnt", 32'(count), 32'd16);
    end
  endtask

  // pat 0: ready always; pat 1: ready 1,0,0,1 repeating
  task automatic readout(input int pat, input bit arm_mid);
    int n;
    int d0;
    n = 0; d0 = done_cnt; nbeats = 0;
    while ((sb_q.size() != 0 || done_cnt == d0) && n < 300) begin
      dout_rdy = (pat == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      arm = arm_mid && (n == 5);
      tick();
      n++;
    end
    arm = 1'b0; dout_rdy = 1'b1;
    chk("rd_timeout", 32'(n < 300), 32'd1);
    chk("rd_beats", 32'(nbeats), 32'd16);
    chk("rd_done_once", 32'(done_cnt - d0), 32'd1);
    chk("rd_done_low", 32'(done), 32'd0);
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_vld", 32'(dout_vld), 32'd0);
    chk("rd_cnt", 32'(count), 32'd16);
    if (pat == 0) chk("b2b_span", 32'(last_beat - first_beat), 32'd15);
    repeat (3) tick();
    chk("rd_no_redone", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Power-up reset
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("por");

    // Asynchronous reset asserted mid-clock while armed
    do_arm();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) tick();
    rst = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Trigger before arm is ignored
    din = 8'h99; din_vld = 1'b1; trig = 1'b1;
    #2;
    chk("idle_trig_wr", 32'(ram_wr), 32'd0);
    tick();
    chk("idle_trig_busy", 32'(busy), 32'd0);
    din_vld = 1'b0; trig = 1'b0;

    // Trigger without din_vld in ARMED is ignored
    do_arm();
    trig = 1'b1;
    #2;
    chk("armed_nvld_wr", 32'(ram_wr), 32'd0);
    tick();
    trig = 1'b0;
    chk("armed_hold_cnt", 32'(count), 32'd0);

    // Contiguous capture, full-rate readout
    capture(8'h10, 1'b0, 16);
    readout(0, 1'b0);

    // Gapped capture, stalling readout
    do_arm();
    capture(8'h30, 1'b1, 16);
    readout(1, 1'b0);

    // Arm during readout is ignored
    do_arm();
    capture(8'hA0, 1'b0, 16);
    readout(0, 1'b1);

    // Reset after 5 captured samples, then a clean snapshot
    do_arm();
    capture(8'hC0, 1'b0, 5);
    din = 8'hC5; din_vld = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_wr", 32'(ram_wr), 32'd0);
    sb_q.delete();
    din_vld = 1'b0;
    tick();
    rst = 1'b0;
    do_arm();
    capture(8'h50, 1'b0, 16);
    readout(0, 1'b0);

`ifdef BRAM_SNAP_ABORT_EN
    // Abort on the third readout beat while stalled
    begin
      int n;
      int d0;
      do_arm();
      capture(8'h70, 1'b0, 16);
      nbeats = 0; n = 0; d0 = done_cnt; dout_rdy = 1'b1;
      while (nbeats < 2 && n < 50) begin
        tick();
        n++;
      end
      chk("ab_timeout", 32'(n < 50), 32'd1);
      dout_rdy = 1'b0; abort_s = 1'b1;
      #2;
      chk("ab_vld_before", 32'(dout_vld), 32'd1);
      chk("ab_dout_before", 32'(dout), 32'h72);
      tick();
      abort_s = 1'b0; dout_rdy = 1'b1;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_vld", 32'(dout_vld), 32'd0);
      chk("ab_cnt", 32'(count), 32'd0);
      sb_q.delete();
      repeat (4) tick();
      chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
